// File: rtl/logic_op_pkg.sv
// Shared types for the logic-op arbiter slice: opcodes, slot state, default width.
package logic_op_pkg;

  localparam int LOGIC_OP_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_t;

endpackage

// File: rtl/logic_op_arbiter_if.sv
// Two request ports plus one response port of the shared logic unit.
interface logic_op_arbiter_if #(
  parameter int WIDTH = logic_op_pkg::LOGIC_OP_WIDTH
);
  logic                      req0_valid;
  logic                      req0_ready;
  logic_op_pkg::op_t         req0_op;
  logic [WIDTH-1:0]          req0_a;
  logic [WIDTH-1:0]          req0_b;

  logic                      req1_valid;
  logic                      req1_ready;
  logic_op_pkg::op_t         req1_op;
  logic [WIDTH-1:0]          req1_a;
  logic [WIDTH-1:0]          req1_b;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_id;
  logic [2*WIDTH-1:0]        rsp_data;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data
  );

  // Requester / consumer side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/logic_op_alu.sv
// Combinational bitwise unit. AND/OR/XOR fill the low half only; NOT inverts
// the concatenation {a,b} across the full result width.
module logic_op_alu
  import logic_op_pkg::*;
#(
  parameter int WIDTH = LOGIC_OP_WIDTH
) (
  input  op_t                op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] y
);

  // Opcode decode; upper half stays zero except for NOT
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y[WIDTH-1:0] = a & b;
      OP_OR:   y[WIDTH-1:0] = a | b;
      OP_XOR:  y[WIDTH-1:0] = a ^ b;
      OP_NOT:  y            = ~{a, b};
      default: y            = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin sharing of one logic unit between two requesters, with a single
// registered response slot. Ready is combinational on rsp_ready so a draining
// slot can reload in the same cycle (one result per cycle sustained).
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int WIDTH = LOGIC_OP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_op_arbiter_if.slave    bus
);

  slot_t              slot_q;
  logic               last_q;     // requester granted on the most recent accept
  logic               rsp_id_q;
  logic [2*WIDTH-1:0] rsp_data_q;

  logic               can_accept;
  logic               grant0, grant1;
  logic               acc0, acc1, acc;
  op_t                mux_op;
  logic [WIDTH-1:0]   mux_a, mux_b;
  logic [2*WIDTH-1:0] alu_y;

  assign bus.rsp_valid = (slot_q == SLOT_FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

  // Slot can take a new result if empty or being drained this cycle
  assign can_accept = !bus.rsp_valid || bus.rsp_ready;

  // Requester 1 wins when alone, or on contention when 0 was granted last.
  // With nobody valid, the idle grant parks on requester 0.
  assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);
  assign grant0 = !grant1;

  // rst_n gating keeps both readies low throughout reset
  assign bus.req0_ready = rst_n && can_accept && grant0;
  assign bus.req1_ready = rst_n && can_accept && grant1;

  assign acc0 = bus.req0_valid && bus.req0_ready;
  assign acc1 = bus.req1_valid && bus.req1_ready;
  assign acc  = acc0 || acc1;

  // Operand mux steered by the accepted requester only, so an idle port's
  // operands never reach the result register
  assign mux_op = acc1 ? bus.req1_op : bus.req0_op;
  assign mux_a  = acc1 ? bus.req1_a  : bus.req0_a;
  assign mux_b  = acc1 ? bus.req1_b  : bus.req0_b;

  logic_op_alu #(.WIDTH(WIDTH)) u_alu (
    .op (mux_op),
    .a  (mux_a),
    .b  (mux_b),
    .y  (alu_y)
  );

  // Slot FSM: load on accept, drain on rsp_ready, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= SLOT_EMPTY;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      last_q     <= 1'b1;   // makes requester 0 the first contention winner
    end else begin
      case (slot_q)
        SLOT_EMPTY: begin
          if (acc) begin
            slot_q     <= SLOT_FULL;
            rsp_id_q   <= acc1;
            rsp_data_q <= alu_y;
            last_q     <= acc1;
          end
        end
        SLOT_FULL: begin
          if (acc) begin
            rsp_id_q   <= acc1;
            rsp_data_q <= alu_y;
            last_q     <= acc1;
          end else if (bus.rsp_ready) begin
            slot_q     <= SLOT_EMPTY;
          end
        end
        default: slot_q <= SLOT_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter plus a short random phase scored against
// a reference op function.
module tb_logic_op_arbiter;
  import logic_op_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic_op_arbiter_if #(.WIDTH(W)) bus();

  logic_op_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_op(input op_t op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [2*W-1:0] r;
    r = '0;
    case (op)
      OP_AND:  r[W-1:0] = a & b;
      OP_OR:   r[W-1:0] = a | b;
      OP_XOR:  r[W-1:0] = a ^ b;
      default: r = ~{a, b};
    endcase
    return r;
  endfunction

  task automatic drv0(input logic v, input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
  endtask

  task automatic drv1(input logic v, input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
  endtask

  initial begin
    logic [7:0] t4_exp [3];
    op_t        t4_op  [3];
    logic [3:0] t4_a   [3];
    logic [3:0] t4_b   [3];
    logic       exp_full, exp_id, mlast, can, eg1, er0, er1, a0p, a1p;
    logic [7:0] exp_data;
    int         acc_cnt [2];

    t4_op[0] = OP_AND; t4_a[0] = 4'hF; t4_b[0] = 4'h3; t4_exp[0] = 8'h03;
    t4_op[1] = OP_OR;  t4_a[1] = 4'h8; t4_b[1] = 4'h1; t4_exp[1] = 8'h09;
    t4_op[2] = OP_XOR; t4_a[2] = 4'h6; t4_b[2] = 4'h3; t4_exp[2] = 8'h05;

    // Reset: req0 valid but ready must stay low
    drv0(1'b1, OP_AND, 4'hC, 4'hA);
    drv1(1'b0, OP_AND, 4'h0, 4'h0);
    bus.rsp_ready = 1'b0;
    #3;
    chk("rst_vld",  bus.rsp_valid, 0);
    chk("rst_id",   bus.rsp_id, 0);
    chk("rst_data", bus.rsp_data, 0);
    chk("rst_rdy0", bus.req0_ready, 0);
    chk("rst_rdy1", bus.req1_ready, 0);

    // req0 alone, AND 1100 & 1010
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("and_rdy0", bus.req0_ready, 1);
    chk("and_rdy1", bus.req1_ready, 0);
    @(negedge clk);
    chk("and_vld",  bus.rsp_valid, 1);
    chk("and_id",   bus.rsp_id, 0);
    chk("and_data", bus.rsp_data, 8'h08);
    bus.req0_valid = 1'b0;

    // req1 alone, three back-to-back ops
    for (int i = 0; i < 3; i++) begin
      drv1(1'b1, t4_op[i], t4_a[i], t4_b[i]);
      #1;
      chk("solo1_rdy1", bus.req1_ready, 1);
      chk("solo1_rdy0", bus.req0_ready, 0);
      @(negedge clk);
      chk("solo1_vld",  bus.rsp_valid, 1);
      chk("solo1_id",   bus.rsp_id, 1);
      chk("solo1_data", bus.rsp_data, t4_exp[i]);
    end

    // Both valid every cycle: grants 0,1,0,1 (pointer left at 1 above)
    drv0(1'b1, OP_OR,  4'h3, 4'h4);
    drv1(1'b1, OP_XOR, 4'hF, 4'h5);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_rdy0", bus.req0_ready, (i % 2) == 0);
      chk("alt_rdy1", bus.req1_ready, (i % 2) == 1);
      @(negedge clk);
      chk("alt_vld",  bus.rsp_valid, 1);
      chk("alt_id",   bus.rsp_id, i % 2);
      chk("alt_data", bus.rsp_data, (i % 2) ? 8'h0A : 8'h07);
    end

    // NOT held under backpressure, req0 pending
    drv0(1'b0, OP_AND, 4'h0, 4'h0);
    drv1(1'b1, OP_NOT, 4'hA, 4'h5);
    #1;
    chk("not_rdy1", bus.req1_ready, 1);
    @(negedge clk);
    chk("not_data", bus.rsp_data, 8'h5A);
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    drv0(1'b1, OP_AND, 4'h6, 4'h3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_rdy0", bus.req0_ready, 0);
      chk("hold_rdy1", bus.req1_ready, 0);
      @(negedge clk);
      chk("hold_vld",  bus.rsp_valid, 1);
      chk("hold_id",   bus.rsp_id, 1);
      chk("hold_data", bus.rsp_data, 8'h5A);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("drain_rdy0", bus.req0_ready, 1);
    @(negedge clk);
    chk("drain_vld",  bus.rsp_valid, 1);
    chk("drain_id",   bus.rsp_id, 0);
    chk("drain_data", bus.rsp_data, 8'h02);

    // Asynchronous reset with slot full and req0 waiting
    bus.rsp_ready = 1'b0;
    drv0(1'b1, OP_XOR, 4'h9, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld",  bus.rsp_valid, 0);
    chk("arst_data", bus.rsp_data, 0);
    chk("arst_rdy0", bus.req0_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drv0(1'b1, OP_OR,  4'h3, 4'h4);
    drv1(1'b1, OP_XOR, 4'hF, 4'h5);
    bus.rsp_ready = 1'b1;
    #1;
    chk("post_rst_rdy0", bus.req0_ready, 1);
    chk("post_rst_rdy1", bus.req1_ready, 0);
    @(negedge clk);
    chk("post_rst_id",   bus.rsp_id, 0);
    chk("post_rst_data", bus.rsp_data, 8'h07);

    // Random phase: req1 still pending, slot full with 07, pointer at 0
    exp_full = 1'b1; exp_id = 1'b0; exp_data = 8'h07; mlast = 1'b0;
    a0p = 1'b1; a1p = 1'b0;
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    for (int c = 0; c < 300; c++) begin
      chk("rnd_vld", bus.rsp_valid, exp_full);
      if (exp_full) begin
        chk("rnd_id",   bus.rsp_id, exp_id);
        chk("rnd_data", bus.rsp_data, exp_data);
      end
      if (!bus.req0_valid || a0p)
        drv0($urandom_range(0, 3) != 0, op_t'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (!bus.req1_valid || a1p)
        drv1($urandom_range(0, 3) != 0, op_t'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      bus.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      can = !exp_full || bus.rsp_ready;
      eg1 = bus.req1_valid && (!bus.req0_valid || !mlast);
      er0 = can && !eg1;
      er1 = can && eg1;
      chk("rnd_rdy0", bus.req0_ready, er0);
      chk("rnd_rdy1", bus.req1_ready, er1);
      a0p = bus.req0_valid && er0;
      a1p = bus.req1_valid && er1;
      if (a0p || a1p) begin
        exp_full = 1'b1;
        exp_id   = a1p;
        exp_data = a1p ? ref_op(bus.req1_op, bus.req1_a, bus.req1_b)
                       : ref_op(bus.req0_op, bus.req0_a, bus.req0_b);
        mlast    = a1p;
        acc_cnt[a1p ? 1 : 0]++;
      end else if (bus.rsp_ready) begin
        exp_full = 1'b0;
      end
      @(negedge clk);
    end
    chk("rnd_both_served", (acc_cnt[0] > 0) && (acc_cnt[1] > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
